// File: rtl/regfile_write_buffer.sv
// In-order writeback buffer in front of the register-file write port, with optional
// youngest-entry lookup for source operands (enabled by defining WB_BYPASS_EN).
module regfile_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               in_reg,
    input  logic [31:0]              in_data,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic                     rf_write,
    output logic [4:0]               rf_write_reg,
    output logic [31:0]              rf_write_data,
    input  logic [4:0]               lkp_reg1,
    input  logic [4:0]               lkp_reg2,
    output logic                     lkp_hit1,
    output logic                     lkp_hit2,
    output logic [31:0]              lkp_data1,
    output logic [31:0]              lkp_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    reg_mem  [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          push;
    logic          enq;
    logic          pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = rst && !full && !flush;
    assign push     = in_valid && in_ready;
    // Writes to r0 are accepted but have no architectural effect, so never stored.
    assign enq      = push && (in_reg != 5'd0);
    assign rf_write = !empty && drain_en && !flush;
    assign pop      = rf_write;

    assign rf_write_reg  = empty ? '0 : reg_mem[rd_ptr];
    assign rf_write_data = empty ? '0 : data_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            reg_mem[wr_ptr]  <= in_reg;
            data_mem[wr_ptr] <= in_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Scan oldest to youngest so the last match (youngest) wins.
    function automatic logic [32:0] lookup(input logic [4:0] r);
        logic [32:0]   res;
        logic [PW-1:0] idx;
        res = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (r != 5'd0) && (reg_mem[idx] == r)) begin
                res = {1'b1, data_mem[idx]};
            end
        end
        return res;
    endfunction

    assign {lkp_hit1, lkp_data1} = lookup(lkp_reg1);
    assign {lkp_hit2, lkp_data2} = lookup(lkp_reg2);
`else
    logic unused_lkp;
    assign unused_lkp = ^{lkp_reg1, lkp_reg2};
    assign lkp_hit1   = 1'b0;
    assign lkp_hit2   = 1'b0;
    assign lkp_data1  = '0;
    assign lkp_data2  = '0;
`endif

endmodule
